alu_arbiter: RTL and testbench

Two-requester controller that shares the single registered 16-bit ALU between independent clients. It accepts one operation at a time over a valid/ready request channel and drives the ALU operand and opcode inputs. It captures the ALU result and zero flag one cycle after issue, then returns them on the granted requester's valid/ready response channel. It sits between the ALU and its clients (e.g. execute stage and address-generation logic); the ALU's `clk`/`reset` are the same nets as this block's.

---
 rtl/alu_arbiter_if.sv | 28 ++
 rtl/alu_arbiter.sv | 78 +++++++
 tb/tb_alu_arbiter.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels of both clients plus the shared ALU bus.
interface alu_arbiter_if #(parameter int WIDTH = 16);
    logic             req0_valid, req0_ready, rsp0_valid, rsp0_ready, rsp0_zero;
    logic [WIDTH-1:0] req0_a, req0_b, rsp0_result;
    logic [2:0]       req0_ctrl;
    logic             req1_valid, req1_ready, rsp1_valid, rsp1_ready, rsp1_zero;
    logic [WIDTH-1:0] req1_a, req1_b, rsp1_result;
    logic [2:0]       req1_ctrl;
    logic [WIDTH-1:0] alu_a, alu_b, alu_r;
    logic [2:0]       alu_ctrl;
    logic             alu_zero;
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
        input  req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
        input  alu_r, alu_zero,
        output req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
        output req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
        output alu_a, alu_b, alu_ctrl
    );
    modport master (
        output req0_valid, req0_a, req0_b, req0_ctrl, rsp0_ready,
        output req1_valid, req1_a, req1_b, req1_ctrl, rsp1_ready,
        output alu_r, alu_zero,
        input  req0_ready, rsp0_valid, rsp0_result, rsp0_zero,
        input  req1_ready, rsp1_valid, rsp1_result, rsp1_zero,
        input  alu_a, alu_b, alu_ctrl
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one registered ALU between two requesters, one operation at a time.
// ALU_ARB_RR_EN selects round-robin arbitration; otherwise requester 0 has fixed priority.
module alu_arbiter #(
    parameter int WIDTH = 16
) (
    input  logic         clk,
    input  logic         reset,
    alu_arbiter_if.slave bus,
    output logic         busy,
    output logic         owner
);
    localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, CAPTURE = 2'd2, RESP = 2'd3;
    logic [1:0]       state_q, state_d;
    logic             owner_q, owner_d, zero_q, zero_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]       ctrl_q, ctrl_d;
    logic             idle, grant, req_hs, rsp_hs;
`ifdef ALU_ARB_RR_EN
    logic ptr_q, ptr_d;
    assign grant = (bus.req0_valid & bus.req1_valid) ? ptr_q : bus.req1_valid;
    assign ptr_d = req_hs ? ~grant : ptr_q;
`else
    assign grant = ~bus.req0_valid;
`endif
    assign idle   = state_q == IDLE;
    assign req_hs = idle & ~reset & (bus.req0_valid | bus.req1_valid);
    assign rsp_hs = (state_q == RESP) & (owner_q ? bus.rsp1_ready : bus.rsp0_ready);
    always_comb begin
        state_d = state_q == RESP ? (rsp_hs ? IDLE : RESP)
                : idle ? (req_hs ? ISSUE : IDLE) : state_q + 2'd1;
        owner_d = req_hs ? grant : owner_q;
        a_d     = req_hs ? (grant ? bus.req1_a : bus.req0_a) : a_q;
        b_d     = req_hs ? (grant ? bus.req1_b : bus.req0_b) : b_q;
        ctrl_d  = req_hs ? (grant ? bus.req1_ctrl : bus.req0_ctrl) : ctrl_q;
        res_d   = state_q == CAPTURE ? bus.alu_r : res_q;
        zero_d  = state_q == CAPTURE ? bus.alu_zero : zero_q;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            ctrl_q  <= '0;
            res_q   <= '0;
            zero_q  <= 1'b0;
`ifdef ALU_ARB_RR_EN
            ptr_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            a_q     <= a_d;
            b_q     <= b_d;
            ctrl_q  <= ctrl_d;
            res_q   <= res_d;
            zero_q  <= zero_d;
`ifdef ALU_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end
    // Ready is gated by the request's own valid so only a real contender sees it.
    assign bus.req0_ready  = req_hs & ~grant & bus.req0_valid;
    assign bus.req1_ready  = req_hs & grant & bus.req1_valid;
    assign bus.rsp0_valid  = (state_q == RESP) & ~owner_q;
    assign bus.rsp1_valid  = (state_q == RESP) & owner_q;
    assign bus.rsp0_result = res_q;
    assign bus.rsp1_result = res_q;
    assign bus.rsp0_zero   = zero_q;
    assign bus.rsp1_zero   = zero_q;
    // Idle ALU is driven with NOP and zero operands so its output stays deterministic.
    assign bus.alu_a    = state_q == ISSUE ? a_q : '0;
    assign bus.alu_b    = state_q == ISSUE ? b_q : '0;
    assign bus.alu_ctrl = state_q == ISSUE ? ctrl_q : 3'd0;
    assign busy  = ~idle;
    assign owner = owner_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of alu_arbiter against a behavioural registered ALU.
module tb_alu_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy, owner;
    int errors = 0;
    int checks = 0;
    alu_arbiter_if #(.WIDTH(16)) bus ();
    alu_arbiter #(.WIDTH(16)) dut (.clk(clk), .reset(reset), .bus(bus), .busy(busy), .owner(owner));
    always #5 clk = ~clk;
    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
        case (c)
            3'd1: return a + b;
            3'd2: return a ^ b;
            3'd3: return a & b;
            3'd4: return a | b;
            3'd5: return ~a;
            3'd6: return ~(a & b);
            3'd7: return ~(a | b);
            default: return 16'h0000;
        endcase
    endfunction
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.alu_r    <= '0;
            bus.alu_zero <= 1'b1;
        end else begin
            bus.alu_r    <= alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl);
            bus.alu_zero <= alu_f(bus.alu_a, bus.alu_b, bus.alu_ctrl) == 16'h0000;
        end
    end
    task automatic run_op(input bit id, input logic [15:0] a, input logic [15:0] b, input logic [2:0] c,
                          output logic [15:0] res, output logic z, output bit ok);
        int n;
        ok = 1'b1;
        @(negedge clk);
        if (id) begin bus.req1_valid = 1; bus.req1_a = a; bus.req1_b = b; bus.req1_ctrl = c; end
        else    begin bus.req0_valid = 1; bus.req0_a = a; bus.req0_b = b; bus.req0_ctrl = c; end
        #1;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) ok = 1'b0;
        @(negedge clk);
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        #1;
        n = 0;
        while (!(id ? bus.rsp1_valid : bus.rsp0_valid) && n < 20) begin @(negedge clk); #1; n++; end
        if (n >= 20) ok = 1'b0;
        res = id ? bus.rsp1_result : bus.rsp0_result;
        z   = id ? bus.rsp1_zero : bus.rsp0_zero;
        @(negedge clk);
    endtask
    task automatic test_reset;
        reset = 1;
        bus.req0_valid = 1; bus.req1_valid = 1;
        bus.req0_a = 16'h0003; bus.req0_b = 16'h0004; bus.req0_ctrl = 3'd1;
        bus.req1_a = 16'h0001; bus.req1_b = 16'h0001; bus.req1_ctrl = 3'd1;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        repeat (2) @(negedge clk);
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin errors++; $display("FAIL reset_ready got=%b want=00", {bus.req0_ready, bus.req1_ready}); end
        checks++;
        if ({bus.rsp0_valid, bus.rsp1_valid, busy, owner} !== 4'b0000) begin errors++; $display("FAIL reset_state got=%b want=0000", {bus.rsp0_valid, bus.rsp1_valid, busy, owner}); end
        checks++;
        if ({bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rsp0_result, bus.rsp0_zero} !== '0) begin errors++; $display("FAIL reset_data got a=%h b=%h c=%0d r=%h z=%b want all 0", bus.alu_a, bus.alu_b, bus.alu_ctrl, bus.rsp0_result, bus.rsp0_zero); end
        @(negedge clk);
        reset = 0;
        bus.req0_valid = 0; bus.req1_valid = 0;
    endtask
    task automatic test_basic;
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_a = 16'h0003; bus.req0_b = 16'h0004; bus.req0_ctrl = 3'd1;
        #1;
        checks++;
        if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin errors++; $display("FAIL basic_ready got=%b want=10", {bus.req0_ready, bus.req1_ready}); end
        @(negedge clk);
        bus.req0_valid = 0;
        #1;
        checks++;
        if (bus.alu_ctrl !== 3'd1 || bus.alu_a !== 16'h0003 || bus.alu_b !== 16'h0004 || busy !== 1'b1)
            begin errors++; $display("FAIL basic_issue got c=%0d a=%h b=%h busy=%b want 1/0003/0004/1", bus.alu_ctrl, bus.alu_a, bus.alu_b, busy); end
        @(negedge clk); #1;
        checks++;
        if (bus.alu_ctrl !== 3'd0 || bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL basic_capture got c=%0d v=%b want 0/0", bus.alu_ctrl, bus.rsp0_valid); end
        @(negedge clk); #1;
        checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_result !== 16'h0007 || bus.rsp0_zero !== 1'b0 || bus.alu_ctrl !== 3'd0)
            begin errors++; $display("FAIL basic_resp got v0=%b v1=%b r=%h z=%b c=%0d want 1/0/0007/0/0", bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_result, bus.rsp0_zero, bus.alu_ctrl); end
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || bus.rsp0_valid !== 1'b0) begin errors++; $display("FAIL basic_idle got busy=%b v=%b want 0/0", busy, bus.rsp0_valid); end
    endtask
    task automatic test_wrap_zero;
        logic [15:0] r; logic z; bit ok;
        run_op(1'b1, 16'hFFFF, 16'h0001, 3'd1, r, z, ok);
        checks++;
        if (!ok || r !== 16'h0000 || z !== 1'b1 || owner !== 1'b1) begin errors++; $display("FAIL add_wrap got ok=%0b r=%h z=%b own=%b want 1/0000/1/1", ok, r, z, owner); end
        run_op(1'b1, 16'h5A5A, 16'h5A5A, 3'd2, r, z, ok);
        checks++;
        if (!ok || r !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL xor_zero got ok=%0b r=%h z=%b want 1/0000/1", ok, r, z); end
        run_op(1'b1, 16'h00FF, 16'h1234, 3'd5, r, z, ok);
        checks++;
        if (!ok || r !== 16'hFF00 || z !== 1'b0) begin errors++; $display("FAIL nota got ok=%0b r=%h z=%b want 1/FF00/0", ok, r, z); end
        run_op(1'b0, 16'hF0F0, 16'h0FF0, 3'd6, r, z, ok);
        checks++;
        if (!ok || r !== 16'hFF0F || z !== 1'b0) begin errors++; $display("FAIL nand got ok=%0b r=%h z=%b want 1/FF0F/0", ok, r, z); end
    endtask
    task automatic test_opcode_zero;
        logic [15:0] r; logic z; bit ok;
        run_op(1'b0, 16'h1234, 16'h5678, 3'd0, r, z, ok);
        checks++;
        if (!ok || r !== 16'h0000 || z !== 1'b1) begin errors++; $display("FAIL opcode0 got ok=%0b r=%h z=%b want 1/0000/1", ok, r, z); end
    endtask
    task automatic test_backpressure;
        int n;
        @(negedge clk);
        bus.rsp0_ready = 0;
        bus.req0_valid = 1; bus.req0_a = 16'h0003; bus.req0_b = 16'h0004; bus.req0_ctrl = 3'd1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL bp_accept got=%b want=1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 0;
        bus.req1_valid = 1; bus.req1_a = 16'h0001; bus.req1_b = 16'h0001; bus.req1_ctrl = 3'd1;
        #1;
        n = 0;
        while (!bus.rsp0_valid && n < 20) begin @(negedge clk); #1; n++; end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.rsp0_valid !== 1'b1 || bus.rsp0_result !== 16'h0007 || bus.req0_ready !== 1'b0 || bus.req1_ready !== 1'b0 || busy !== 1'b1)
                begin errors++; $display("FAIL bp_hold%0d got v=%b r=%h rdy=%b%b busy=%b want 1/0007/00/1", i, bus.rsp0_valid, bus.rsp0_result, bus.req0_ready, bus.req1_ready, busy); end
            if (i < 4) begin @(negedge clk); #1; end
        end
        bus.rsp0_ready = 1;
        @(negedge clk); #1;
        checks++;
        if (busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.req1_ready !== 1'b1)
            begin errors++; $display("FAIL bp_release got busy=%b v0=%b rdy1=%b want 0/0/1", busy, bus.rsp0_valid, bus.req1_ready); end
        @(negedge clk);
        bus.req1_valid = 0;
        #1;
        n = 0;
        while (!bus.rsp1_valid && n < 20) begin @(negedge clk); #1; n++; end
        checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp1_result !== 16'h0002 || bus.rsp0_valid !== 1'b0)
            begin errors++; $display("FAIL bp_pending got v1=%b r=%h v0=%b want 1/0002/0", bus.rsp1_valid, bus.rsp1_result, bus.rsp0_valid); end
        @(negedge clk);
    endtask
    task automatic test_reset_mid;
        bit seen;
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_a = 16'h0003; bus.req0_b = 16'h0004; bus.req0_ctrl = 3'd1;
        #1;
        checks++;
        if (bus.req0_ready !== 1'b1) begin errors++; $display("FAIL rmid_accept got=%b want=1", bus.req0_ready); end
        @(negedge clk);
        bus.req0_valid = 0;
        @(negedge clk);
        reset = 1;
        @(negedge clk); #1;
        checks++;
        if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || busy !== 1'b0 || bus.alu_ctrl !== 3'd0)
            begin errors++; $display("FAIL rmid_state got v=%b%b busy=%b c=%0d want 00/0/0", bus.rsp0_valid, bus.rsp1_valid, busy, bus.alu_ctrl); end
        reset = 0;
        seen = 0;
        repeat (6) begin @(negedge clk); #1; if (bus.rsp0_valid || bus.rsp1_valid || busy) seen = 1; end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rmid_noresp got activity=%b want=0", seen); end
    endtask
    task automatic test_arbitration;
        bit ids [4];
        logic [15:0] res [4];
        bit exp_ids [4];
        int got, n;
`ifdef ALU_ARB_RR_EN
        exp_ids = '{1'b0, 1'b1, 1'b0, 1'b1};
`else
        exp_ids = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        @(negedge clk);
        reset = 1;
        bus.req0_valid = 1; bus.req0_a = 16'hF0F0; bus.req0_b = 16'h0FF0; bus.req0_ctrl = 3'd3;
        bus.req1_valid = 1; bus.req1_a = 16'h000F; bus.req1_b = 16'h00F0; bus.req1_ctrl = 3'd4;
        @(negedge clk);
        reset = 0;
        got = 0; n = 0;
        while (got < 4 && n < 40) begin
            @(negedge clk); #1; n++;
            if (bus.rsp0_valid || bus.rsp1_valid) begin
                ids[got] = bus.rsp1_valid;
                res[got] = bus.rsp1_valid ? bus.rsp1_result : bus.rsp0_result;
                got++;
            end
        end
        bus.req0_valid = 0; bus.req1_valid = 0;
        checks++;
        if (got !== 4) begin errors++; $display("FAIL arb_count got=%0d want=4", got); end
        for (int i = 0; i < got; i++) begin
            checks++;
            if (ids[i] !== exp_ids[i] || res[i] !== (exp_ids[i] ? 16'h00FF : 16'h00F0))
                begin errors++; $display("FAIL arb_%0d got id=%0d r=%h want id=%0d r=%h", i, ids[i], res[i], exp_ids[i], exp_ids[i] ? 16'h00FF : 16'h00F0); end
        end
        repeat (2) @(negedge clk);
    endtask
    initial begin
        bus.req0_valid = 0; bus.req1_valid = 0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req0_ctrl = '0;
        bus.req1_a = '0; bus.req1_b = '0; bus.req1_ctrl = '0;
        bus.rsp0_ready = 1; bus.rsp1_ready = 1;
        test_reset;
        test_basic;
        test_wrap_zero;
        test_backpressure;
        test_opcode_zero;
        test_reset_mid;
        test_arbitration;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
